reg_bus_master: RTL

Bus initiator for the PWM register interface. It accepts read/write commands on a valid/ready port, queues them in a small FIFO, and issues single-cycle `wen`/`ren` transactions on the `addr`/`wdata`/`rdata` register bus. Read data returns on a valid/ready response port. It sits between a command source (host bridge or sequencer) and the register block, and replaces hand-driven bus tasks in the system.

---
 rtl/reg_bus_master_if.sv | 37 +++
 rtl/reg_bus_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_bus_master_if.sv
// Command, register-bus and response signals of reg_bus_master.
//   command : cmd_valid/cmd_ready handshake with cmd_write, cmd_addr, cmd_wdata
//   bus     : addr, wdata, wen, ren out; rdata in
//   response: rsp_valid/rsp_ready handshake with rsp_addr, rsp_rdata
//   status  : busy
// Modport master is the bus initiator view; slave is the environment view
// (command source, register block and response consumer together).
interface reg_bus_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rdata, rsp_ready,
    output cmd_ready, addr, wdata, wen, ren, rsp_valid, rsp_addr, rsp_rdata, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rdata, rsp_ready,
    input  cmd_ready, addr, wdata, wen, ren, rsp_valid, rsp_addr, rsp_rdata, busy
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register-bus initiator. Commands are queued in a FIFO_DEPTH-entry FIFO and
// issued one at a time as single-cycle wen/ren strobes; read data is captured
// RD_LATENCY cycles after the ren cycle and returned on the response port.
// Ports:
//   clk     : single rising-edge clock
//   reset_n : asynchronous active-low reset (aborts any transaction, flushes FIFO)
//   bus     : reg_bus_master_if.master (command, register bus, response, busy)
// Parameters: ADDR_W, DATA_W, FIFO_DEPTH (power of two, >= 2),
//             RD_LATENCY (0..3).
module reg_bus_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input logic              clk,
  input logic              reset_n,
  reg_bus_master_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              fifo_write_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [FIFO_DEPTH];

  logic              push, pop, full, empty;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        lat_q, lat_d;

  // cmd_ready does not look ahead at a same-cycle pop, so a full FIFO
  // always refuses for one cycle even while the head is being popped.
  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.cmd_valid && !full;

  assign count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  // FIFO storage carries no reset; only pointers and count define its content.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= bus.cmd_write;
      fifo_addr_q[wr_ptr_q]  <= bus.cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lat_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Bus outputs are registered, so each branch computes the value the bus
  // shows during the state being entered: the pop in IDLE already loads the
  // strobe, address and data seen throughout WRITE/READ.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    lat_d       = lat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        addr_d  = '0;
        wdata_d = '0;
        if (!empty) begin
          pop    = 1'b1;
          addr_d = fifo_addr_q[rd_ptr_q];
          if (fifo_write_q[rd_ptr_q]) begin
            wdata_d = fifo_wdata_q[rd_ptr_q];
            wen_d   = 1'b1;
            state_d = S_WRITE;
          end else begin
            ren_d   = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        addr_d  = '0;
        wdata_d = '0;
        state_d = S_IDLE;
      end
      S_READ: begin
        if (RD_LATENCY == 0) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_rdata_d = bus.rdata;
          addr_d      = '0;
          state_d     = S_RESP;
        end else begin
          lat_d   = 2'(RD_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // addr holds here so the register block may decode it late.
        lat_d = lat_q - 2'd1;
        if (lat_q == 2'd1) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_rdata_d = bus.rdata;
          addr_d      = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        addr_d  = '0;
        wdata_d = '0;
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = !full;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.wen       = wen_q;
  assign bus.ren       = ren_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = !empty || (state_q != S_IDLE);
endmodule
